// File: rtl/bus_initiator_pkg.sv
// Shared types and constants for the 8-bit peripheral bus initiator.
package bus_initiator_pkg;

  localparam int unsigned BUS_W    = 8;
  localparam int unsigned IRQ_ID_W = 3;
  localparam int unsigned WAIT_W   = 3;

  localparam logic [BUS_W-1:0] IDLE_ADDR_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_WAIT,
    ST_RD_SAMPLE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Host request/response handshake plus the unidirectional bus address/strobe lines.
interface bus_initiator_if;
  import bus_initiator_pkg::*;

  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_WE;
  logic [BUS_W-1:0] REQ_ADDR;
  logic [BUS_W-1:0] REQ_WDATA;
  logic             RSP_VALID;
  logic [BUS_W-1:0] RSP_RDATA;
  logic [BUS_W-1:0] BUS_ADDR;
  logic             BUS_WE;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, BUS_ADDR, BUS_WE
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, BUS_ADDR, BUS_WE
  );

endinterface

// File: rtl/bus_initiator_irq_latch.sv
// Interrupt front end: synchronise raise lines, latch rising edges as pending,
// pick the lowest pending index and clear it on acknowledge.
module bus_initiator_irq_latch
  import bus_initiator_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_IRQ-1:0]  raise,
  input  logic [NUM_IRQ-1:0]  mask,
  input  logic                ack,
  output logic                irq_pending,
  output logic [IRQ_ID_W-1:0] irq_id
);

  logic [NUM_IRQ-1:0]  sync1_q, sync2_q, sync_d_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  rise_c, ack_c;
  logic                irq_pending_q;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;

  // Set wins over ack on the same bit; ack only targets the currently reported ID.
  always_comb begin
    rise_c = sync2_q & ~sync_d_q & mask;
    ack_c  = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      ack_c[i] = ack && pending_q[i] && (irq_id_q == IRQ_ID_W'(i));
    end
    pending_d = (pending_q & ~ack_c) | rise_c;
    irq_id_d  = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending_d[i]) irq_id_d = IRQ_ID_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      sync_d_q      <= '0;
      pending_q     <= '0;
      irq_pending_q <= 1'b0;
      irq_id_q      <= '0;
    end else begin
      sync1_q       <= raise;
      sync2_q       <= sync1_q;
      sync_d_q      <= sync2_q;
      pending_q     <= pending_d;
      irq_pending_q <= |pending_d;
      irq_id_q      <= irq_id_d;
    end
  end

  assign irq_pending = irq_pending_q;
  assign irq_id      = irq_id_q;

endmodule

// File: rtl/bus_initiator.sv
// Bus initiator: turns single-beat host requests into 8-bit peripheral bus cycles
// and fronts the peripherals' interrupt lines.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int unsigned      NUM_IRQ   = 4,
  parameter logic [BUS_W-1:0] IDLE_ADDR = IDLE_ADDR_DEFAULT,
  parameter int unsigned      READ_WAIT = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  bus_initiator_if.master     bus,
  inout  wire  [BUS_W-1:0]    BUS_DATA,
  input  logic [NUM_IRQ-1:0]  BUS_INTERRUPTS_RAISE,
  output logic                IRQ_PENDING,
  output logic [IRQ_ID_W-1:0] IRQ_ID,
  input  logic                IRQ_ACK,
  input  logic [NUM_IRQ-1:0]  IRQ_MASK
);

  state_e            state_q, state_d;
  logic [BUS_W-1:0]  bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic              data_oe_q, data_oe_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [BUS_W-1:0]  rdata_q, rdata_d;
  req_t              req_c;

  assign req_c = '{we: bus.REQ_WE, addr: bus.REQ_ADDR, wdata: bus.REQ_WDATA};

  // Next-state and next-output logic; every bus output is registered below.
  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    data_oe_d   = 1'b0;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID && ready_q) begin
          bus_addr_d = req_c.addr;
          bus_we_d   = req_c.we;
          data_oe_d  = req_c.we;
          wdata_d    = req_c.wdata;
          wait_d     = WAIT_W'(READ_WAIT - 1);
          state_d    = req_c.we ? ST_WR : ST_RD_WAIT;
        end
      end
      ST_WR: begin
        bus_addr_d  = IDLE_ADDR;
        bus_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RD_WAIT: begin
        if (wait_q == '0) state_d = ST_RD_SAMPLE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      ST_RD_SAMPLE: begin
        rdata_d     = BUS_DATA;
        bus_addr_d  = IDLE_ADDR;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      bus_addr_q  <= IDLE_ADDR;
      bus_we_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      wdata_q     <= '0;
      wait_q      <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      data_oe_q   <= data_oe_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Registered enable: the data bus is only ever driven during the WR beat.
  assign BUS_DATA      = data_oe_q ? wdata_q : {BUS_W{1'bz}};
  assign bus.BUS_ADDR  = bus_addr_q;
  assign bus.BUS_WE    = bus_we_q;
  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rdata_q;

  bus_initiator_irq_latch #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_latch (
    .CLK         (CLK),
    .RESET       (RESET),
    .raise       (BUS_INTERRUPTS_RAISE),
    .mask        (IRQ_MASK),
    .ack         (IRQ_ACK),
    .irq_pending (IRQ_PENDING),
    .irq_id      (IRQ_ID)
  );

endmodule
